mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle memory access controller between the CPU datapath and the unified word-indexed `Memory` block. It arbitrates between an instruction-fetch port and a load/store data port, and drives `Address`, `writeData` and `writeEnable` into `Memory`. It registers the returned `MemData` into an instruction register or a memory-data register and reports completion with one-cycle valid pulses. Out-of-range addresses are faulted without touching memory.

## Interface
- `MEM_DEPTH`, 1024: number of words in `Memory`; valid addresses are 0..MEM_DEPTH-1.
- `STARVE_MAX`, 4: number of consecutive lost arbitrations after which fetch wins once.
- `Clk`  in  1  clock, rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until accepted.
- `if_addr`  in  32  fetch word address.
- `if_ready`  out  1  fetch accepted this cycle.
- `if_valid`  out  1  one-cycle pulse when the fetch completes.
- `if_fault`  out  1  with `if_valid`: address was out of range.
- `if_instr`  out  32  instruction register.
- `d_req`  in  1  data request; held until accepted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data word address.
- `d_wdata`  in  32  store data.
- `d_ready`  out  1  data request accepted this cycle.
- `d_valid`  out  1  one-cycle completion pulse.
- `d_fault`  out  1  with `d_valid`: address was out of range.
- `d_rdata`  out  32  memory-data register.
- `mem_addr`  out  32  to `Memory.Address`.
- `mem_wdata`  out  32  to `Memory.writeData`.
- `mem_we`  out  1  to `Memory.writeEnable`.
- `mem_rdata`  in  32  from `Memory.MemData`; combinational read.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
  - IDLE → ACCESS on an accepted request.
  - ACCESS → DONE unconditionally.
  - DONE → IDLE unconditionally.
- **Acceptance:** only in IDLE. Exactly one of `if_ready`/`d_ready` is high, combinationally, in that cycle. The controller latches the address, the write data, `d_we`, the port id, and `fault = (addr >= MEM_DEPTH)`.
- **Arbitration:**
  - The data port has priority.
  - A starvation counter counts IDLE cycles in which both requests are present and data wins.
  - When the counter reaches `STARVE_MAX`, the next contested IDLE cycle grants fetch and the counter clears.
  - The counter also clears on any fetch grant.
  - The counter saturates and never wraps.
- **ACCESS:**
  - `mem_addr` is driven from the latched address.
  - Store without fault: `mem_we` = 1 for exactly this cycle, so `Memory` writes on the closing edge.
  - Read without fault: `mem_rdata` is captured at the closing edge into `if_instr` or `d_rdata`, according to port.
  - Fault: `mem_we` = 0, no capture, and the target register loads 0 on a faulted read.
- **DONE:**
  - The matching `*_valid` pulses for one cycle.
  - `*_fault` equals the latched fault bit during that pulse and is 0 otherwise.
  - Stores do not modify `d_rdata`.
- **Register hold:** `if_instr` and `d_rdata` keep their values until the next read on their own port.
- **Outside ACCESS:** `mem_we` = 0, and `mem_addr`/`mem_wdata` hold their last values.
- **Reset values:** state IDLE; every output 0, including `if_instr`, `d_rdata` and `mem_addr`; starvation counter 0.
- **Reset mid-operation:** asserting `Rst_n` low during ACCESS drops `mem_we` asynchronously, so no write occurs. No valid pulse is issued for the aborted transaction.

## Timing
- Request accepted in cycle T, memory access in T+1, `*_valid` in T+2.
- Next acceptance possible at T+3, so sustained throughput is one transaction per 3 cycles.
- `*_ready` is combinational from `*_req` and the state. All other outputs are registered, except `mem_we`, which decodes state ACCESS gated by the latched store-and-not-fault bit.
- Address comparison is unsigned on the full 32 bits. Addresses 0x400 and 0xFFFFFFFF both fault.
- A request deasserted before acceptance is simply dropped. A request held during ACCESS or DONE waits and is not accepted twice.

## Structure
- Package `mem_ctrl_pkg`: state encoding constants (IDLE=0, ACCESS=1, DONE=2), `MEM_DEPTH`, `STARVE_MAX`, and the port-id constants (PORT_IF=0, PORT_D=1).
- Sub-module `mem_access_arb`: grant logic plus the saturating starvation counter. Inputs are `if_req`, `d_req` and an `idle` flag; outputs are the two grants. The top level holds the FSM and the datapath registers.

## Test plan
- **Fetch:** memory preloaded with word[128]=0x00221820; `if_req`=1, `if_addr`=128 → `if_ready` at T, `if_valid` at T+2, `if_instr`=0x00221820, `if_fault`=0.
- **Store then load:** store `d_addr`=6, `d_wdata`=0xDEADBEEF → `mem_we` high for exactly 1 cycle and `d_valid` at T+2. A following load from address 6 → `d_rdata`=0xDEADBEEF.
- **Contention:** `if_req` and `d_req` held continuously → data granted 4 times, then fetch granted once, and the pattern repeats. Each grant is spaced 3 cycles apart.
- **Fault:** store to `d_addr`=1024 → `mem_we` never asserts, `d_valid` and `d_fault` are 1 at T+2, and word[0..1023] is unchanged. Fetch at 0xFFFFFFFF → `if_instr`=0, `if_fault`=1.
- **Reset mid-operation:** `Rst_n` pulled low during the ACCESS cycle of a store to address 5 → `mem_we` drops immediately, word[5] keeps its old value, no `d_valid`, and every output reads 0 after reset.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory access controller: FSM state encoding,
// default memory depth and starvation limit, port identifiers, and the
// address range check used when a request is accepted.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int MEM_DEPTH  = 1024;
  localparam int STARVE_MAX = 4;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Unsigned compare on the full 32-bit address, so huge addresses fault too.
  function automatic logic addr_fault(input logic [31:0] addr, input int depth);
    return (addr >= $unsigned(depth));
  endfunction

endpackage

// File: rtl/mem_access_arb.sv
// mem_access_arb
// Grant logic between the fetch and data ports plus the saturating
// starvation counter that lets fetch through after repeated losses.
// Ports:
//   Clk, Rst_n      clock / asynchronous active-low reset
//   if_req, d_req   pending requests from the two ports
//   idle            controller is in IDLE and may accept
//   if_gnt, d_gnt   combinational one-hot grants (both 0 when not idle)
module mem_access_arb #(
  parameter int STARVE_MAX = mem_ctrl_pkg::STARVE_MAX
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic idle,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          starved;
  logic          contested;

  assign starved   = (cnt_reg >= CNT_MAX);
  assign contested = idle && if_req && d_req;

  // Data wins unless fetch has lost enough contested rounds in a row.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (idle) begin
      if (d_req && !(if_req && starved)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Only contested losses count; any fetch grant restarts the window.
  always_comb begin
    cnt_next = cnt_reg;
    if (if_gnt) begin
      cnt_next = '0;
    end else if (contested && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Three-cycle memory access controller between the CPU fetch/data ports and
// a unified word-indexed memory with combinational read.
// Ports:
//   Clk, Rst_n                         clock / asynchronous active-low reset
//   if_req/if_addr                     fetch request
//   if_ready/if_valid/if_fault/if_instr fetch handshake and instruction register
//   d_req/d_we/d_addr/d_wdata          load/store request
//   d_ready/d_valid/d_fault/d_rdata    data handshake and memory-data register
//   mem_addr/mem_wdata/mem_we          drive to memory
//   mem_rdata                          combinational read data from memory
module mem_access_ctrl #(
  parameter int MEM_DEPTH  = mem_ctrl_pkg::MEM_DEPTH,
  parameter int STARVE_MAX = mem_ctrl_pkg::STARVE_MAX
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic        if_fault,
  output logic [31:0] if_instr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_valid,
  output logic        d_fault,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  import mem_ctrl_pkg::*;

  state_t state_reg;
  state_t state_next;
  logic   if_gnt;
  logic   d_gnt;
  logic   idle;
  logic   we_reg;
  logic   port_reg;
  logic   fault_reg;

  assign idle = (state_reg == IDLE);

  mem_access_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .if_req(if_req),
    .d_req (d_req),
    .idle  (idle),
    .if_gnt(if_gnt),
    .d_gnt (d_gnt)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (if_gnt || d_gnt) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_we decodes the state register directly so an asynchronous reset
  // during ACCESS removes the write before the closing edge.
  always_comb begin
    if_ready = if_gnt;
    d_ready  = d_gnt;
    mem_we   = (state_reg == ACCESS) && we_reg && !fault_reg;
  end

  // Datapath: latch on acceptance, capture at the end of ACCESS, and raise
  // the completion pulse for the DONE cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_reg    <= 1'b0;
      port_reg  <= PORT_IF;
      fault_reg <= 1'b0;
      if_valid  <= 1'b0;
      if_fault  <= 1'b0;
      if_instr  <= '0;
      d_valid   <= 1'b0;
      d_fault   <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      if_fault <= 1'b0;
      d_valid  <= 1'b0;
      d_fault  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (d_gnt) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            we_reg    <= d_we;
            port_reg  <= PORT_D;
            fault_reg <= addr_fault(d_addr, MEM_DEPTH);
          end else if (if_gnt) begin
            mem_addr  <= if_addr;
            we_reg    <= 1'b0;
            port_reg  <= PORT_IF;
            fault_reg <= addr_fault(if_addr, MEM_DEPTH);
          end
        end
        ACCESS: begin
          if (port_reg == PORT_IF) begin
            if_valid <= 1'b1;
            if_fault <= fault_reg;
            if_instr <= fault_reg ? '0 : mem_rdata;
          end else begin
            d_valid <= 1'b1;
            d_fault <= fault_reg;
            if (!we_reg) begin
              d_rdata <= fault_reg ? '0 : mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int DEPTH  = 1024;
  localparam int STARVE = 4;

  logic        Clk;
  logic        Rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_valid, if_fault;
  logic [31:0] if_instr;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_valid, d_fault;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_instr = '0;
  logic [31:0] exp_drdata = '0;

  mem_access_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_fault(if_fault), .if_instr(if_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_fault(d_fault), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory environment: preload image plus written-word overlay.
  logic [31:0] init_mem [0:DEPTH-1];
  logic [31:0] wr_mem   [0:DEPTH-1];
  bit          wr_flag  [0:DEPTH-1];
  logic [31:0] ref_mem  [0:DEPTH-1];

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return wr_flag[a] ? wr_mem[a] : init_mem[a];
  endfunction

  assign mem_rdata = (mem_addr < 32'd1024) ? mem_word(mem_addr[9:0]) : 32'hBAADF00D;

  always @(posedge Clk) begin
    if (mem_we && mem_addr < 32'd1024) begin
      wr_mem[mem_addr[9:0]]  <= mem_wdata;
      wr_flag[mem_addr[9:0]] <= 1'b1;
    end
  end

  // Reference: what a completed transaction must return.
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return (a >= 32'(DEPTH)) ? 32'h0 : ref_mem[a[9:0]];
  endfunction

  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int rdy_at, output int vld_at,
                         output int vld_cnt, output int we_cnt, output logic flt,
                         output logic [31:0] rdata);
    rdy_at = -1; vld_at = -1; vld_cnt = 0; we_cnt = 0; flt = 1'bx; rdata = 'x;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (rdy_at < 0 && (is_d ? d_ready : if_ready)) rdy_at = c;
      if (mem_we) we_cnt++;
      if (is_d ? d_valid : if_valid) begin
        vld_at = c; vld_cnt++;
        flt   = is_d ? d_fault : if_fault;
        rdata = is_d ? d_rdata : if_instr;
      end
      @(posedge Clk); #1;
      if (rdy_at >= 0) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({if_instr, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_regs if_instr=%h d_rdata=%h expected 0", if_instr, d_rdata);
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_we} !== 65'h0) begin
      errors++; $display("FAIL reset_mem addr=%h wdata=%h we=%b expected 0", mem_addr, mem_wdata, mem_we);
    end
    checks++;
    if ({if_ready, if_valid, if_fault, d_ready, d_valid, d_fault} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b expected 000000",
                         {if_ready, if_valid, if_fault, d_ready, d_valid, d_fault});
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    $display("reset: done");
  endtask

  task automatic test_fetch();
    int ra, va, vc, wc; logic f; logic [31:0] r;
    run_txn(1'b0, 1'b0, 32'd128, 32'h0, ra, va, vc, wc, f, r);
    exp_instr = ref_read(32'd128);
    checks++;
    if (ra !== 0 || va !== 2 || vc !== 1) begin
      errors++; $display("FAIL fetch_timing ready_at=%0d valid_at=%0d pulses=%0d expected 0/2/1", ra, va, vc);
    end
    checks++;
    if (r !== 32'h00221820 || f !== 1'b0) begin
      errors++; $display("FAIL fetch_data instr=%h fault=%b expected 00221820/0", r, f);
    end
    checks++;
    if (wc !== 0) begin
      errors++; $display("FAIL fetch_we we_cycles=%0d expected 0", wc);
    end
    $display("fetch: addr=128 instr=%h fault=%b", r, f);
  endtask

  task automatic test_store_load();
    int ra, va, vc, wc; logic f; logic [31:0] r;
    run_txn(1'b1, 1'b1, 32'd6, 32'hDEADBEEF, ra, va, vc, wc, f, r);
    ref_mem[6] = 32'hDEADBEEF;
    checks++;
    if (wc !== 1 || va !== 2 || vc !== 1 || f !== 1'b0) begin
      errors++; $display("FAIL store_basic we_cycles=%0d valid_at=%0d pulses=%0d fault=%b expected 1/2/1/0",
                         wc, va, vc, f);
    end
    checks++;
    if (r !== exp_drdata) begin
      errors++; $display("FAIL store_keeps_rdata d_rdata=%h expected %h", r, exp_drdata);
    end
    $display("store: addr=6 data=deadbeef we_cycles=%0d", wc);
    run_txn(1'b1, 1'b0, 32'd6, 32'h0, ra, va, vc, wc, f, r);
    exp_drdata = ref_read(32'd6);
    checks++;
    if (r !== 32'hDEADBEEF || f !== 1'b0 || va !== 2) begin
      errors++; $display("FAIL load_back d_rdata=%h fault=%b valid_at=%0d expected deadbeef/0/2", r, f, va);
    end
    checks++;
    if (if_instr !== exp_instr) begin
      errors++; $display("FAIL instr_hold if_instr=%h expected %h", if_instr, exp_instr);
    end
    $display("load: addr=6 data=%h", r);
  endtask

  task automatic test_fault();
    int ra, va, vc, wc, bad; logic f; logic [31:0] r;
    run_txn(1'b1, 1'b1, 32'd1024, 32'h12345678, ra, va, vc, wc, f, r);
    checks++;
    if (wc !== 0 || va !== 2 || f !== 1'b1) begin
      errors++; $display("FAIL store_fault we_cycles=%0d valid_at=%0d fault=%b expected 0/2/1", wc, va, f);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem_word(10'(i)) !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mem_untouched changed_words=%0d expected 0", bad);
    end
    $display("store fault: addr=400 fault=%b", f);
    run_txn(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, ra, va, vc, wc, f, r);
    exp_instr = 32'h0;
    checks++;
    if (r !== 32'h0 || f !== 1'b1 || va !== 2) begin
      errors++; $display("FAIL fetch_fault instr=%h fault=%b valid_at=%0d expected 0/1/2", r, f, va);
    end
    $display("fetch fault: addr=ffffffff instr=%h fault=%b", r, f);
    run_txn(1'b1, 1'b0, 32'h400, 32'h0, ra, va, vc, wc, f, r);
    exp_drdata = 32'h0;
    checks++;
    if (r !== 32'h0 || f !== 1'b1) begin
      errors++; $display("FAIL load_fault d_rdata=%h fault=%b expected 0/1", r, f);
    end
    $display("load fault: addr=400 data=%h fault=%b", r, f);
    run_txn(1'b0, 1'b0, 32'h3FF, 32'h0, ra, va, vc, wc, f, r);
    exp_instr = ref_read(32'h3FF);
    checks++;
    if (r !== exp_instr || f !== 1'b0) begin
      errors++; $display("FAIL fetch_top_word instr=%h fault=%b expected %h/0", r, f, exp_instr);
    end
    $display("fetch edge: addr=3ff instr=%h fault=%b", r, f);
    // Fault pulses must not linger once the transaction is over.
    checks++;
    if (if_fault !== 1'b0 || d_fault !== 1'b0) begin
      errors++; $display("FAIL fault_idle if_fault=%b d_fault=%b expected 0/0", if_fault, d_fault);
    end
  endtask

  task automatic test_contention();
    int last, lost, ngr;
    bit exp_if;
    logic [31:0] fa, da;
    fa = 32'($urandom_range(0, 1023));
    da = 32'($urandom_range(0, 1023));
    if_req = 1'b1; if_addr = fa;
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    last = -1; lost = 0; ngr = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge Clk);
      if (if_ready && d_ready) begin
        checks++; errors++;
        $display("FAIL contend_onehot cycle=%0d both ready", c);
      end else if (if_ready || d_ready) begin
        exp_if = (lost == STARVE);
        checks++;
        if (if_ready !== exp_if) begin
          errors++; $display("FAIL contend_winner grant=%0d if_ready=%b expected %b", ngr, if_ready, exp_if);
        end
        if (last >= 0) begin
          checks++;
          if (c - last != 3) begin
            errors++; $display("FAIL contend_spacing grant=%0d gap=%0d expected 3", ngr, c - last);
          end
        end
        $display("contend: cycle=%0d grant=%s", c, if_ready ? "fetch" : "data");
        last = c; ngr++;
        lost = exp_if ? 0 : lost + 1;
      end
      @(posedge Clk); #1;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    checks++;
    if (ngr != 15) begin
      errors++; $display("FAIL contend_count grants=%0d expected 15", ngr);
    end
    exp_instr = ref_read(fa);
    exp_drdata = ref_read(da);
    checks++;
    if (if_instr !== exp_instr || d_rdata !== exp_drdata) begin
      errors++; $display("FAIL contend_data instr=%h rdata=%h expected %h/%h",
                         if_instr, d_rdata, exp_instr, exp_drdata);
    end
  endtask

  task automatic test_random();
    int ra, va, vc, wc, sel; logic f; logic [31:0] r, a, wd, er;
    bit is_d, we, ef;
    for (int n = 0; n < 40; n++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d && ($urandom_range(0, 1) == 1);
      sel  = $urandom_range(0, 9);
      if (sel == 0)      a = 32'd1024 + 32'($urandom_range(0, 4000));
      else if (sel == 1) a = $urandom | 32'h8000_0000;
      else if (sel == 2) a = 32'($urandom_range(0, 1023));
      else               a = 32'($urandom_range(0, 15));
      wd = $urandom;
      run_txn(is_d, we, a, wd, ra, va, vc, wc, f, r);
      ef = (a >= 32'(DEPTH));
      if (!is_d)      begin exp_instr = ref_read(a); er = exp_instr; end
      else if (!we)   begin exp_drdata = ref_read(a); er = exp_drdata; end
      else begin
        er = exp_drdata;
        if (!ef) ref_mem[a[9:0]] = wd;
      end
      checks++;
      if (ra !== 0 || va !== 2 || vc !== 1 || f !== ef || r !== er ||
          wc !== ((is_d && we && !ef) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_txn n=%0d port=%0d we=%0d addr=%h got rdy=%0d vld=%0d n=%0d we_cyc=%0d flt=%b data=%h expected 0/2/1/%0d/%b/%h",
                 n, is_d, we, a, ra, va, vc, wc, f, r, (is_d && we && !ef) ? 1 : 0, ef, er);
      end
      checks++;
      if (if_instr !== exp_instr || d_rdata !== exp_drdata) begin
        errors++; $display("FAIL rand_hold n=%0d instr=%h rdata=%h expected %h/%h",
                           n, if_instr, d_rdata, exp_instr, exp_drdata);
      end
      $display("rand: n=%0d port=%s we=%0d addr=%h data=%h fault=%b", n, is_d ? "d" : "if", we, a, r, f);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] old5, wd;
    int dv;
    old5 = ref_mem[5];
    wd = ~old5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd5; d_wdata = wd;
    @(negedge Clk);
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_accept d_ready=%b expected 1", d_ready);
    end
    @(posedge Clk); #1;
    d_req = 1'b0;
    checks++;
    if (mem_we !== 1'b1) begin
      errors++; $display("FAIL rstmid_we_access mem_we=%b expected 1", mem_we);
    end
    #2; Rst_n = 1'b0; #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_we_drop mem_we=%b expected 0", mem_we);
    end
    dv = 0;
    repeat (3) begin @(negedge Clk); if (d_valid) dv++; end
    checks++;
    if (mem_word(10'd5) !== old5) begin
      errors++; $display("FAIL rstmid_word5 word=%h expected %h", mem_word(10'd5), old5);
    end
    checks++;
    if ({if_ready, if_valid, if_fault, if_instr, d_ready, d_valid, d_fault, d_rdata,
         mem_addr, mem_wdata, mem_we} !== '0) begin
      errors++; $display("FAIL rstmid_outputs instr=%h rdata=%h addr=%h wdata=%h expected all 0",
                         if_instr, d_rdata, mem_addr, mem_wdata);
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    repeat (4) begin @(negedge Clk); if (d_valid) dv++; end
    checks++;
    if (dv != 0) begin
      errors++; $display("FAIL rstmid_no_valid pulses=%0d expected 0", dv);
    end
    checks++;
    if ({if_instr, d_rdata, mem_addr, mem_we, if_valid, d_valid} !== '0) begin
      errors++; $display("FAIL rstmid_after instr=%h rdata=%h addr=%h expected 0",
                         if_instr, d_rdata, mem_addr);
    end
    $display("reset mid: word5=%h valid_pulses=%0d", mem_word(10'd5), dv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_mem[128] = 32'h00221820;
    ref_mem[128]  = 32'h00221820;
    test_reset();
    test_fetch();
    test_store_load();
    test_fault();
    test_contention();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
